// File: rtl/leaderboard_pkg.sv
// Shared widths, sentinel and encodings for the stopwatch top-3 leaderboard.
package leaderboard_pkg;

    localparam int TW = 22;
    localparam logic [TW-1:0] EMPTY_VAL = {TW{1'b1}};

    typedef enum logic [1:0] {
        SW_IDLE    = 2'b00,
        SW_STOPPED = 2'b01,
        SW_RUNNING = 2'b10,
        SW_PAUSED  = 2'b11
    } sw_mode_e;

    localparam logic [2:0] DISP_LIVE  = 3'b000;
    localparam logic [2:0] DISP_R1    = 3'b100;
    localparam logic [2:0] DISP_R2    = 3'b101;
    localparam logic [2:0] DISP_R3    = 3'b110;
    localparam logic [2:0] DISP_BLANK = 3'b111;

    typedef enum logic [1:0] {
        V_NONE   = 2'b00,
        V_FAST   = 2'b01,
        V_SLOW   = 2'b10,
        V_PLACED = 2'b11
    } verdict_e;

    // Unused slots read back as zero on the display.
    function automatic logic [TW-1:0] show_slot(input logic [TW-1:0] v);
        return (v == EMPTY_VAL) ? '0 : v;
    endfunction

endpackage

// File: rtl/leaderboard_rank.sv
// Ranks a time against the sorted 3-entry table (1..4, ties placed after existing).
// Purely combinational; no backpressure.
module leaderboard_rank
    import leaderboard_pkg::*;
(
    input  logic [TW-1:0] entry1_i,
    input  logic [TW-1:0] entry2_i,
    input  logic [TW-1:0] entry3_i,
    input  logic [TW-1:0] time_i,
    output logic [2:0]    rank_o
);

    logic le1, le2, le3;

    always_comb begin
        le1    = (entry1_i != EMPTY_VAL) && (entry1_i <= time_i);
        le2    = (entry2_i != EMPTY_VAL) && (entry2_i <= time_i);
        le3    = (entry3_i != EMPTY_VAL) && (entry3_i <= time_i);
        rank_o = 3'd1 + {2'b00, le1} + {2'b00, le2} + {2'b00, le3};
    end

endmodule

// File: rtl/leaderboard.sv
// Top-3 lowest-time table updated on each entry into STOPPED, plus display mux.
// Latency: 1 cycle from mode change to table/LED/sound/verdict; no backpressure.
module leaderboard
    import leaderboard_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic [TW-1:0] time_in,
    input  logic [1:0]    stopwatch_mode,
    input  logic [2:0]    display_mode,
    output logic [TW-1:0] leaderboard_number,
    output logic          signal_sound_1,
    output logic          signal_sound_2,
    output logic          signal_sound_3,
    output logic [2:0]    leaderboard_LED,
    output logic [1:0]    slow_or_fast
);

    logic [TW-1:0] entry1_q, entry1_d;
    logic [TW-1:0] entry2_q, entry2_d;
    logic [TW-1:0] entry3_q, entry3_d;
    logic [1:0]    prev_mode_q;
    logic [2:0]    led_q, led_d;
    logic [2:0]    sound_q, sound_d;
    verdict_e      verdict_q, verdict_d;
    logic [2:0]    rank;
    logic          submit;

    leaderboard_rank u_rank (
        .entry1_i (entry1_q),
        .entry2_i (entry2_q),
        .entry3_i (entry3_q),
        .time_i   (time_in),
        .rank_o   (rank)
    );

    // Zero and the sentinel are not real times, so such submissions change nothing.
    assign submit = (prev_mode_q != SW_STOPPED) && (stopwatch_mode == SW_STOPPED)
                 && (time_in != '0) && (time_in != EMPTY_VAL);

    always_comb begin
        entry1_d  = entry1_q;
        entry2_d  = entry2_q;
        entry3_d  = entry3_q;
        led_d     = led_q;
        verdict_d = verdict_q;
        sound_d   = 3'b000;
        if (submit) begin
            case (rank)
                3'd1: begin
                    entry1_d  = time_in;
                    entry2_d  = entry1_q;
                    entry3_d  = entry2_q;
                    led_d     = 3'b001;
                    sound_d   = 3'b001;
                    verdict_d = V_FAST;
                end
                3'd2: begin
                    entry2_d  = time_in;
                    entry3_d  = entry2_q;
                    led_d     = 3'b010;
                    sound_d   = 3'b010;
                    verdict_d = V_PLACED;
                end
                3'd3: begin
                    entry3_d  = time_in;
                    led_d     = 3'b100;
                    sound_d   = 3'b100;
                    verdict_d = V_PLACED;
                end
                default: begin
                    led_d     = 3'b000;
                    verdict_d = V_SLOW;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry1_q    <= EMPTY_VAL;
            entry2_q    <= EMPTY_VAL;
            entry3_q    <= EMPTY_VAL;
            prev_mode_q <= SW_IDLE;
            led_q       <= 3'b000;
            sound_q     <= 3'b000;
            verdict_q   <= V_NONE;
        end else begin
            entry1_q    <= entry1_d;
            entry2_q    <= entry2_d;
            entry3_q    <= entry3_d;
            prev_mode_q <= stopwatch_mode;
            led_q       <= led_d;
            sound_q     <= sound_d;
            verdict_q   <= verdict_d;
        end
    end

    always_comb begin
        case (display_mode)
            DISP_R1:    leaderboard_number = show_slot(entry1_q);
            DISP_R2:    leaderboard_number = show_slot(entry2_q);
            DISP_R3:    leaderboard_number = show_slot(entry3_q);
            DISP_BLANK: leaderboard_number = '0;
            default:    leaderboard_number = time_in;
        endcase
    end

    assign signal_sound_1  = sound_q[0];
    assign signal_sound_2  = sound_q[1];
    assign signal_sound_3  = sound_q[2];
    assign leaderboard_LED = led_q;
    assign slow_or_fast    = verdict_q;

endmodule

// File: tb/tb_leaderboard.sv
// Directed self-checking bench for leaderboard: ranking, ties, drops, display mux, reset.
module tb_leaderboard;
    import leaderboard_pkg::*;

    logic          clk;
    logic          rst_n;
    logic [TW-1:0] time_in;
    logic [1:0]    stopwatch_mode;
    logic [2:0]    display_mode;
    logic [TW-1:0] leaderboard_number;
    logic          signal_sound_1, signal_sound_2, signal_sound_3;
    logic [2:0]    leaderboard_LED;
    logic [1:0]    slow_or_fast;

    int tests_run = 0;
    int tests_failed = 0;

    leaderboard dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .time_in            (time_in),
        .stopwatch_mode     (stopwatch_mode),
        .display_mode       (display_mode),
        .leaderboard_number (leaderboard_number),
        .signal_sound_1     (signal_sound_1),
        .signal_sound_2     (signal_sound_2),
        .signal_sound_3     (signal_sound_3),
        .leaderboard_LED    (leaderboard_LED),
        .slow_or_fast       (slow_or_fast)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_table(input string tag, input int e1, input int e2, input int e3);
        display_mode = DISP_R1; #1;
        check({tag, "_e1"}, 32'(leaderboard_number), e1);
        display_mode = DISP_R2; #1;
        check({tag, "_e2"}, 32'(leaderboard_number), e2);
        display_mode = DISP_R3; #1;
        check({tag, "_e3"}, 32'(leaderboard_number), e3);
    endtask

    task automatic check_outs(input string tag, input int snd, input int led, input int v);
        check({tag, "_snd"}, 32'({signal_sound_3, signal_sound_2, signal_sound_1}), snd);
        check({tag, "_led"}, 32'(leaderboard_LED), led);
        check({tag, "_vrd"}, 32'(slow_or_fast), v);
    endtask

    // Leave STOPPED, then re-enter it with time t; returns just after the sampling edge.
    task automatic submit(input int t);
        stopwatch_mode = SW_RUNNING;
        time_in = TW'(t);
        tick();
        stopwatch_mode = SW_STOPPED;
        tick();
    endtask

    initial begin
        rst_n = 1'b1;
        time_in = TW'(143000);
        stopwatch_mode = SW_STOPPED;
        display_mode = DISP_R1;
        #2 rst_n = 1'b0;
        #1;
        check_table("rst", 0, 0, 0);
        display_mode = DISP_BLANK; #1;
        check("rst_blank", 32'(leaderboard_number), 0);
        check_outs("rst", 0, 0, 0);

        // Mode already STOPPED when reset lifts: first edge submits.
        tick(); tick();
        #3 rst_n = 1'b1;
        tick();
        check_outs("first", 3'b001, 3'b001, 2'b01);
        check_table("first", 143000, 0, 0);
        tick();
        check_outs("first_after", 0, 3'b001, 2'b01);

        // Staying in STOPPED with a new time never resubmits.
        time_in = TW'(142000);
        tick(); tick();
        check_outs("hold", 0, 3'b001, 2'b01);
        check_table("hold", 143000, 0, 0);

        submit(142000);
        check_outs("best2", 3'b001, 3'b001, 2'b01);
        check_table("best2", 142000, 143000, 0);

        submit(150000);
        check_outs("r3", 3'b100, 3'b100, 2'b11);
        check_table("r3", 142000, 143000, 150000);

        submit(139000);
        check_outs("best3", 3'b001, 3'b001, 2'b01);
        check_table("best3", 139000, 142000, 143000);

        submit(160000);
        check_outs("slow", 0, 0, 2'b10);
        check_table("slow", 139000, 142000, 143000);

        display_mode = DISP_LIVE;
        time_in = TW'(150000); #1;
        check("live", 32'(leaderboard_number), 150000);
        display_mode = 3'b011; #1;
        check("live_011", 32'(leaderboard_number), 150000);

        submit(0);
        check_outs("zero", 0, 0, 2'b10);
        check_table("zero", 139000, 142000, 143000);

        submit(int'(EMPTY_VAL));
        check_outs("sentinel", 0, 0, 2'b10);
        check_table("sentinel", 139000, 142000, 143000);

        // Asynchronous clear between edges.
        #2 rst_n = 1'b0;
        #1;
        check_table("arst", 0, 0, 0);
        check_outs("arst", 0, 0, 0);
        #2 rst_n = 1'b1;
        stopwatch_mode = SW_IDLE;
        tick();

        submit(300);
        submit(200);
        submit(100);
        check_table("tieset", 100, 200, 300);

        // Equal time ranks after the existing 200, so it lands third.
        submit(200);
        check_outs("tie", 3'b100, 3'b100, 2'b11);
        check_table("tie", 100, 200, 200);

        submit(150);
        check_outs("r2", 3'b010, 3'b010, 2'b11);
        check_table("r2", 100, 150, 200);
        tick();
        check_outs("r2_after", 0, 3'b010, 2'b11);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
